ctrl_sequencer: RTL and testbench



---
 rtl/ctrl_seq_pkg.sv | 18 +
 rtl/ctrl_seq_if.sv | 47 ++++
 rtl/ctrl_seq_dwell.sv | 32 +++
 rtl/ctrl_sequencer.sv | 119 +++++++++++
 tb/tb_ctrl_sequencer.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_seq_pkg.sv
// ctrl_seq_pkg: shared types and helpers for the control sequencer.
// FSM state encoding and the step-count clamp.
package ctrl_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  // Zero steps runs one step; oversize requests run every strobe.
  function automatic int clamp_steps(input int n, input int max_n);
    if (n < 1) return 1;
    if (n > max_n) return max_n;
    return n;
  endfunction

endpackage

// File: rtl/ctrl_seq_if.sv
// ctrl_seq_if: controller <-> sequencer start/busy/done bundle.
// Optional pause signal when CTRL_SEQ_PAUSE_EN is defined.
interface ctrl_seq_if #(
  parameter int NUM_STEPS = 4,
  parameter int HOLD_W    = 4
);
  localparam int IDX_W = $clog2(NUM_STEPS);

  logic                 start;
  logic [IDX_W:0]       num_steps;
  logic [HOLD_W-1:0]    hold_cycles;
  logic                 loop;
  logic                 abort;
`ifdef CTRL_SEQ_PAUSE_EN
  logic                 pause;
`endif
  logic [NUM_STEPS-1:0] step_sel;
  logic [IDX_W-1:0]     step_idx;
  logic                 busy;
  logic                 done;
  logic                 wrap;

`ifdef CTRL_SEQ_PAUSE_EN
  modport master (
    output start, num_steps, hold_cycles,
    output loop, abort, pause,
    input  step_sel, step_idx, busy, done, wrap
  );
  modport slave (
    input  start, num_steps, hold_cycles,
    input  loop, abort, pause,
    output step_sel, step_idx, busy, done, wrap
  );
`else
  modport master (
    output start, num_steps, hold_cycles,
    output loop, abort,
    input  step_sel, step_idx, busy, done, wrap
  );
  modport slave (
    input  start, num_steps, hold_cycles,
    input  loop, abort,
    output step_sel, step_idx, busy, done, wrap
  );
`endif

endinterface

// File: rtl/ctrl_seq_dwell.sv
// ctrl_seq_dwell: per-step dwell counter.
// Clear wins over enable; tc_o flags count == limit.
module ctrl_seq_dwell #(
  parameter int HOLD_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [HOLD_W-1:0] lim_i,
  output logic              tc_o
);

  logic [HOLD_W-1:0] cnt_q;
  logic [HOLD_W-1:0] cnt_d;

  // Next count: clear, advance, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + HOLD_W'(1);
  end

  // Count register, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == lim_i);

endmodule

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: one-hot step strobe sequencer with per-step dwell.
// Define CTRL_SEQ_PAUSE_EN to add the pause input.
module ctrl_sequencer
  import ctrl_seq_pkg::*;
#(
  parameter int NUM_STEPS = 4,
  parameter int HOLD_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  ctrl_seq_if.slave  seq_if
);

  localparam int IDX_W = $clog2(NUM_STEPS);
  localparam int NW    = IDX_W + 1;

  seq_state_e           state_q;
  logic [NUM_STEPS-1:0] sel_q;
  logic [IDX_W-1:0]     idx_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 wrap_q;
  logic [NW-1:0]        n_q;
  logic [HOLD_W-1:0]    h_q;
  logic                 loop_q;

  logic pause;
  logic tc;
  logic last;
  logic run;
  logic dw_clr;
  logic dw_en;

`ifdef CTRL_SEQ_PAUSE_EN
  assign pause = seq_if.pause;
`else
  assign pause = 1'b0;
`endif

  assign run    = (state_q == RUN);
  assign last   = ({1'b0, idx_q} == (n_q - NW'(1)));
  assign dw_clr = !run || seq_if.abort || (tc && !pause);
  assign dw_en  = run && !pause;

  ctrl_seq_dwell #(
    .HOLD_W (HOLD_W)
  ) u_dwell (
    .clk   (clk),
    .rst   (rst),
    .clr_i (dw_clr),
    .en_i  (dw_en),
    .lim_i (h_q),
    .tc_o  (tc)
  );

  // Sequencer FSM with registered strobes and status pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
      n_q     <= '0;
      h_q     <= '0;
      loop_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      wrap_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (seq_if.start) begin
            n_q     <= NW'(clamp_steps(int'(seq_if.num_steps),
                                       NUM_STEPS));
            h_q     <= seq_if.hold_cycles;
            loop_q  <= seq_if.loop;
            state_q <= RUN;
            sel_q   <= NUM_STEPS'(1);
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          if (seq_if.abort) begin
            state_q <= IDLE;
            sel_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
          end else if (!pause && tc) begin
            if (!last) begin
              idx_q <= idx_q + IDX_W'(1);
              sel_q <= sel_q << 1;
            end else if (loop_q) begin
              idx_q  <= '0;
              sel_q  <= NUM_STEPS'(1);
              wrap_q <= 1'b1;
            end else begin
              state_q <= DONE;
              sel_q   <= '0;
              idx_q   <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign seq_if.step_sel = sel_q;
  assign seq_if.step_idx = idx_q;
  assign seq_if.busy     = busy_q;
  assign seq_if.done     = done_q;
  assign seq_if.wrap     = wrap_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb_ctrl_sequencer: self-checking bench for ctrl_sequencer.
// Arithmetic timeline model; pause test when CTRL_SEQ_PAUSE_EN.
module tb_ctrl_sequencer;

  localparam int NS = 4;
  localparam int HW = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ctrl_seq_if #(.NUM_STEPS(NS), .HOLD_W(HW)) sif ();

  ctrl_sequencer #(
    .NUM_STEPS (NS),
    .HOLD_W    (HW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .seq_if (sif)
  );

  int checks = 0;
  int errors = 0;

  logic [NS-1:0] e_sel;
  logic [IW-1:0] e_idx;
  logic          e_busy;
  logic          e_done;
  logic          e_wrap;

  wire [NS+IW+2:0] obs = {sif.step_sel, sif.step_idx,
                          sif.busy, sif.done, sif.wrap};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int clampn(input int nr);
    return (nr < 1) ? 1 : ((nr > NS) ? NS : nr);
  endfunction

  // Expected outputs 'a' edges after the start edge.
  // ab: cycle in which abort is held (-1: never).
  task automatic model(input int a, input int nr, input int h,
                       input bit lp, input int ab);
    int n, L, T, s;
    n = clampn(nr);
    L = h + 1;
    T = n * L;
    e_sel = '0; e_idx = '0;
    e_busy = 1'b0; e_done = 1'b0; e_wrap = 1'b0;
    if (ab >= 0 && a > ab) return;
    if (lp || a < T) begin
      s = (a % T) / L;
      e_idx  = IW'(s);
      e_sel  = NS'(1) << s;
      e_busy = 1'b1;
      e_wrap = lp && (a > 0) && ((a % T) == 0);
    end else if (a == T) begin
      e_done = 1'b1;
    end
  endtask

  task automatic go(input int nr, input int h, input bit lp);
    sif.num_steps   = (IW+1)'(nr);
    sif.hold_cycles = HW'(h);
    sif.loop        = lp;
    sif.start       = 1'b1;
    tick();
    sif.start       = 1'b0;
    sif.num_steps   = (IW+1)'($urandom);
    sif.hold_cycles = HW'($urandom);
    sif.loop        = 1'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    sif.start = 1'b1;
    sif.num_steps = 3'd3;
    tick(); tick();
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL reset_hold got %b want 0", obs);
    end
    rst = 1'b1;
    sif.start = 1'b0;
    tick();
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL reset_release got %b want 0", obs);
    end
  endtask

  task automatic test_basic();
    go(4, 0, 1'b0);
    for (int a = 0; a <= 6; a++) begin
      model(a, 4, 0, 1'b0, -1);
      checks++;
      if (obs !== {e_sel, e_idx, e_busy, e_done, e_wrap}) begin
        errors++;
        $display("FAIL basic a=%0d got %b want %b", a, obs,
                 {e_sel, e_idx, e_busy, e_done, e_wrap});
      end
      tick();
    end
  endtask

  task automatic test_dwell();
    go(2, 2, 1'b0);
    for (int a = 0; a <= 8; a++) begin
      model(a, 2, 2, 1'b0, -1);
      checks++;
      if (obs !== {e_sel, e_idx, e_busy, e_done, e_wrap}) begin
        errors++;
        $display("FAIL dwell a=%0d got %b want %b", a, obs,
                 {e_sel, e_idx, e_busy, e_done, e_wrap});
      end
      sif.start = (a == 2 || a == 6);
      tick();
      sif.start = 1'b0;
    end
  endtask

  task automatic test_clamp();
    go(0, 0, 1'b0);
    for (int a = 0; a <= 3; a++) begin
      model(a, 0, 0, 1'b0, -1);
      checks++;
      if (obs !== {e_sel, e_idx, e_busy, e_done, e_wrap}) begin
        errors++;
        $display("FAIL clamp0 a=%0d got %b want %b", a, obs,
                 {e_sel, e_idx, e_busy, e_done, e_wrap});
      end
      tick();
    end
    go(7, 0, 1'b0);
    for (int a = 0; a <= 6; a++) begin
      model(a, 7, 0, 1'b0, -1);
      checks++;
      if (obs !== {e_sel, e_idx, e_busy, e_done, e_wrap}) begin
        errors++;
        $display("FAIL clamp7 a=%0d got %b want %b", a, obs,
                 {e_sel, e_idx, e_busy, e_done, e_wrap});
      end
      tick();
    end
  endtask

  // Abort at a=15 lands on a step-advance cycle (dwell 1 of 0..1).
  task automatic test_loop_abort();
    go(3, 1, 1'b1);
    for (int a = 0; a <= 18; a++) begin
      model(a, 3, 1, 1'b1, 15);
      checks++;
      if (obs !== {e_sel, e_idx, e_busy, e_done, e_wrap}) begin
        errors++;
        $display("FAIL loop_abort a=%0d got %b want %b", a, obs,
                 {e_sel, e_idx, e_busy, e_done, e_wrap});
      end
      sif.abort = (a == 15);
      tick();
      sif.abort = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    go(3, 1, 1'b0);
    for (int a = 0; a <= 2; a++) begin
      model(a, 3, 1, 1'b0, -1);
      checks++;
      if (obs !== {e_sel, e_idx, e_busy, e_done, e_wrap}) begin
        errors++;
        $display("FAIL rst_mid_pre a=%0d got %b want %b", a, obs,
                 {e_sel, e_idx, e_busy, e_done, e_wrap});
      end
      if (a < 2) tick();
    end
    rst = 1'b0;
    tick();
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL rst_mid got %b want 0", obs);
    end
    rst = 1'b1;
    tick();
    go(3, 1, 1'b0);
    for (int a = 0; a <= 8; a++) begin
      model(a, 3, 1, 1'b0, -1);
      checks++;
      if (obs !== {e_sel, e_idx, e_busy, e_done, e_wrap}) begin
        errors++;
        $display("FAIL rst_mid_post a=%0d got %b want %b", a, obs,
                 {e_sel, e_idx, e_busy, e_done, e_wrap});
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      int nr, h, T, ab, len, gap;
      bit lp;
      nr = int'($urandom_range(0, 7));
      h  = int'($urandom_range(0, 3));
      lp = 1'($urandom_range(0, 1));
      T  = clampn(nr) * (h + 1);
      if (lp) ab = int'($urandom_range(0, 3 * T));
      else if ($urandom_range(0, 1) == 1)
        ab = int'($urandom_range(0, T + 1));
      else ab = -1;
      len = lp ? ab + 2 : T + 2;
      go(nr, h, lp);
      for (int a = 0; a <= len; a++) begin
        model(a, nr, h, lp, ab);
        checks++;
        if (obs !== {e_sel, e_idx, e_busy, e_done, e_wrap}) begin
          errors++;
          $display("FAIL random it=%0d n=%0d h=%0d lp=%0d a=%0d got %b want %b",
                   it, nr, h, lp, a, obs,
                   {e_sel, e_idx, e_busy, e_done, e_wrap});
        end
        sif.abort = (a == ab) ? 1'b1 : 1'($urandom_range(0, 1) & (a > T) & !lp);
        tick();
        sif.abort = 1'b0;
      end
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) tick();
    end
  endtask

`ifdef CTRL_SEQ_PAUSE_EN
  // Pause held for 5 edges starting in step 1 shifts the timeline by 5.
  task automatic test_pause();
    int eff;
    go(3, 1, 1'b0);
    for (int a = 0; a <= 13; a++) begin
      eff = a;
      if (a > 2) eff = a - ((a - 2 > 5) ? 5 : (a - 2));
      model(eff, 3, 1, 1'b0, -1);
      checks++;
      if (obs !== {e_sel, e_idx, e_busy, e_done, e_wrap}) begin
        errors++;
        $display("FAIL pause a=%0d got %b want %b", a, obs,
                 {e_sel, e_idx, e_busy, e_done, e_wrap});
      end
      if (a == 2) sif.pause = 1'b1;
      if (a == 7) sif.pause = 1'b0;
      tick();
    end
  endtask
`endif

  initial begin
    sif.start       = 1'b0;
    sif.num_steps   = '0;
    sif.hold_cycles = '0;
    sif.loop        = 1'b0;
    sif.abort       = 1'b0;
`ifdef CTRL_SEQ_PAUSE_EN
    sif.pause       = 1'b0;
`endif
    test_reset();
    test_basic();
    test_dwell();
    test_clamp();
    test_loop_abort();
    test_reset_mid();
    test_random();
`ifdef CTRL_SEQ_PAUSE_EN
    test_pause();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
